// File: rtl/uc_menu_navegavel_if.sv
// Menu controller bundle: button/sender/game inputs and screen/handshake outputs.
// master: the menu controller (drives envia_dados, iniciar, screen code, debug state).
// slave : the surrounding system (jogada register, serial sender, base game).
interface uc_menu_navegavel_if #(
    parameter int unsigned TELA_W   = 8,
    parameter int unsigned CURSOR_W = 2
);
    logic                ocorreu_jogada;
    logic                tiro;
    logic                especial;
    logic                fim_envia_dados;
    logic                pronto;
    logic                reset_reg_jogada;
    logic                enable_reg_jogada;
    logic                envia_dados;
    logic                iniciar;
    logic                jogo_base_em_andamento;
    logic                timeout_menu;
    logic [CURSOR_W-1:0] cursor;
    logic [TELA_W-1:0]   tela_renderizada;
    logic [3:0]          db_estado;

    modport master (
        input  ocorreu_jogada, tiro, especial, fim_envia_dados, pronto,
        output reset_reg_jogada, enable_reg_jogada, envia_dados, iniciar,
               jogo_base_em_andamento, timeout_menu, cursor, tela_renderizada, db_estado
    );

    modport slave (
        output ocorreu_jogada, tiro, especial, fim_envia_dados, pronto,
        input  reset_reg_jogada, enable_reg_jogada, envia_dados, iniciar,
               jogo_base_em_andamento, timeout_menu, cursor, tela_renderizada, db_estado
    );
endinterface

// File: rtl/uc_menu_navegavel.sv
// Menu controller for AstroGenius: moves a cursor over the main menu, opens info
// pages, starts the base game and walks the end-of-game screens. Every screen change
// is one envia_dados/fim_envia_dados handshake; idle inactivity returns to the menu.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (master) : ocorreu_jogada/tiro/especial, fim_envia_dados, pronto in;
//                  jogada register control, envia_dados, iniciar, jogo_base_em_andamento,
//                  timeout_menu, cursor, tela_renderizada, db_estado out
module uc_menu_navegavel #(
    parameter int unsigned TELA_W   = 8,
    parameter int unsigned N_OPCOES = 4,
    parameter int unsigned CURSOR_W = 2,
    parameter int unsigned OPC_BASE = 3,
    parameter int unsigned TIMEOUT  = 50_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    uc_menu_navegavel_if.master  bus
);
    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_INICIAL      = 4'd0,
        S_MENU         = 4'd1,
        S_REGISTRA     = 4'd2,
        S_DECIDE       = 4'd3,
        S_ENVIA        = 4'd4,
        S_ESPERA_ENVIA = 4'd5,
        S_INICIAR      = 4'd6,
        S_ESPERA_JOGO  = 4'd7,
        S_TELA_FINAL   = 4'd8,
        S_REG_PONT     = 4'd9,
        S_OPCAO        = 4'd10,
        S_ERRO         = 4'd15
    } estado_t;

    estado_t             state_q, state_d;
    estado_t             dest_q, dest_d;
    estado_t             origem_q, origem_d;
    logic [CURSOR_W-1:0] cursor_q, cursor_d;
    logic [TELA_W-1:0]   tela_q, tela_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic                ocioso;
    logic                armado;

    // Idle states accept button events; the timer only runs in armed idle states.
    always_comb begin
        ocioso = (state_q == S_MENU) || (state_q == S_TELA_FINAL) ||
                 (state_q == S_REG_PONT) || (state_q == S_OPCAO);
        armado = (TIMEOUT != 0) &&
                 ((state_q == S_TELA_FINAL) || (state_q == S_REG_PONT) ||
                  (state_q == S_OPCAO) || ((state_q == S_MENU) && (cursor_q != '0)));
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_INICIAL;
            dest_q    <= S_MENU;
            origem_q  <= S_MENU;
            cursor_q  <= '0;
            tela_q    <= TELA_W'(1);
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            origem_q  <= origem_d;
            cursor_q  <= cursor_d;
            tela_q    <= tela_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state; a screen change loads tela/dest together with the move to ENVIA.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        origem_d  = origem_q;
        cursor_d  = cursor_q;
        tela_d    = tela_q;
        timer_d   = '0;
        timeout_d = 1'b0;
        case (state_q)
            S_INICIAL: begin
                tela_d  = TELA_W'(1);
                dest_d  = S_MENU;
                state_d = S_ENVIA;
            end
            S_MENU, S_TELA_FINAL, S_REG_PONT, S_OPCAO: begin
                // A jogada in the same cycle as the timeout takes precedence.
                if (bus.ocorreu_jogada) begin
                    origem_d = state_q;
                    state_d  = S_REGISTRA;
                end else if (armado) begin
                    if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        cursor_d  = '0;
                        tela_d    = TELA_W'(1);
                        dest_d    = S_MENU;
                        state_d   = S_ENVIA;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            S_REGISTRA: state_d = S_DECIDE;
            S_DECIDE: begin
                state_d = origem_q;
                case (origem_q)
                    S_MENU: begin
                        if (bus.tiro) begin
                            if (cursor_q == '0) begin
                                state_d = S_INICIAR;
                            end else begin
                                tela_d  = TELA_W'(OPC_BASE) + TELA_W'(cursor_q);
                                dest_d  = S_OPCAO;
                                state_d = S_ENVIA;
                            end
                        end else if (bus.especial) begin
                            cursor_d = (cursor_q == CURSOR_W'(N_OPCOES - 1)) ? '0
                                                                             : cursor_q + CURSOR_W'(1);
                            tela_d   = TELA_W'(1);
                            dest_d   = S_MENU;
                            state_d  = S_ENVIA;
                        end
                    end
                    S_TELA_FINAL: begin
                        if (bus.tiro) begin
                            tela_d  = TELA_W'(3);
                            dest_d  = S_REG_PONT;
                            state_d = S_ENVIA;
                        end else if (bus.especial) begin
                            cursor_d = '0;
                            tela_d   = TELA_W'(1);
                            dest_d   = S_MENU;
                            state_d  = S_ENVIA;
                        end
                    end
                    S_REG_PONT: begin
                        if (bus.tiro) begin
                            cursor_d = '0;
                            tela_d   = TELA_W'(1);
                            dest_d   = S_MENU;
                            state_d  = S_ENVIA;
                        end
                    end
                    S_OPCAO: begin
                        if (!bus.tiro && bus.especial) begin
                            tela_d  = TELA_W'(1);
                            dest_d  = S_MENU;
                            state_d = S_ENVIA;
                        end
                    end
                    default: state_d = S_ERRO;
                endcase
            end
            S_ENVIA:        state_d = S_ESPERA_ENVIA;
            S_ESPERA_ENVIA: if (bus.fim_envia_dados) state_d = dest_q;
            S_INICIAR: begin
                cursor_d = '0;
                state_d  = S_ESPERA_JOGO;
            end
            S_ESPERA_JOGO: begin
                if (bus.pronto) begin
                    tela_d  = TELA_W'(2);
                    dest_d  = S_TELA_FINAL;
                    state_d = S_ENVIA;
                end
            end
            S_ERRO:  state_d = S_ERRO;
            default: state_d = S_ERRO;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        bus.reset_reg_jogada       = (state_q == S_INICIAL);
        bus.enable_reg_jogada      = (state_q == S_REGISTRA);
        bus.envia_dados            = (state_q == S_ENVIA);
        bus.iniciar                = (state_q == S_INICIAR);
        bus.jogo_base_em_andamento = (state_q == S_INICIAR) || (state_q == S_ESPERA_JOGO);
        bus.timeout_menu           = timeout_q;
        bus.cursor                 = cursor_q;
        bus.tela_renderizada       = tela_q;
        bus.db_estado              = state_q;
    end
endmodule

// File: tb/tb_uc_menu_navegavel.sv
// Scoreboard bench for uc_menu_navegavel (TIMEOUT=10): each expected send/start is
// queued by the stimulus; a monitor pops and checks on every envia_dados/iniciar pulse.
module tb_uc_menu_navegavel;
    localparam logic [3:0] E_INICIAL = 4'd0, E_MENU = 4'd1, E_REGISTRA = 4'd2,
                           E_ENVIA = 4'd4, E_ESPERA_ENVIA = 4'd5, E_ESPERA_JOGO = 4'd7,
                           E_TELA_FINAL = 4'd8, E_REG_PONT = 4'd9, E_OPCAO = 4'd10;

    typedef struct packed {
        logic       inicio;   // 1: iniciar pulse, 0: envia_dados pulse
        logic [7:0] tela;
        logic [1:0] cursor;
        logic       tmo;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic auto_fim = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t fila[$];

    uc_menu_navegavel_if #(.TELA_W(8), .CURSOR_W(2)) bus ();

    uc_menu_navegavel #(
        .TELA_W(8), .N_OPCOES(4), .CURSOR_W(2), .OPC_BASE(3), .TIMEOUT(10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_send(input logic [7:0] t, input logic [1:0] c, input logic tmo);
        exp_t e;
        e.inicio = 1'b0; e.tela = t; e.cursor = c; e.tmo = tmo;
        fila.push_back(e);
    endtask

    task automatic push_start();
        exp_t e;
        e.inicio = 1'b1; e.tela = 8'd1; e.cursor = 2'd0; e.tmo = 1'b0;
        fila.push_back(e);
    endtask

    // Bounded wait for a state; an expired budget is a failed comparison.
    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int n = 0;
        @(negedge clock);
        while (bus.db_estado !== s && n < budget) begin
            n++;
            @(negedge clock);
        end
        chk(nm, 32'(bus.db_estado), 32'(s));
    endtask

    // One button event from an idle state; tiro/especial held through DECIDE.
    task automatic press(input logic t, input logic e);
        @(posedge clock); #1;
        bus.ocorreu_jogada = 1'b1; bus.tiro = t; bus.especial = e;
        @(posedge clock); #1;
        bus.ocorreu_jogada = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.tiro = 1'b0; bus.especial = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_estado"},   32'(bus.db_estado), 32'(E_INICIAL));
        chk({tag, "_rst_reg"},  32'(bus.reset_reg_jogada), 32'd1);
        chk({tag, "_en_reg"},   32'(bus.enable_reg_jogada), 32'd0);
        chk({tag, "_envia"},    32'(bus.envia_dados), 32'd0);
        chk({tag, "_iniciar"},  32'(bus.iniciar), 32'd0);
        chk({tag, "_jogo"},     32'(bus.jogo_base_em_andamento), 32'd0);
        chk({tag, "_timeout"},  32'(bus.timeout_menu), 32'd0);
        chk({tag, "_cursor"},   32'(bus.cursor), 32'd0);
        chk({tag, "_tela"},     32'(bus.tela_renderizada), 32'd1);
    endtask

    // Serial sender model: fim_envia_dados 3 cycles after envia_dados.
    initial begin : sender
        bus.fim_envia_dados = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && bus.envia_dados === 1'b1 && auto_fim) begin
                repeat (3) @(posedge clock);
                #1 bus.fim_envia_dados = 1'b1;
                @(posedge clock);
                #1 bus.fim_envia_dados = 1'b0;
            end
        end
    end

    // Monitor: every send/start pulse must match the head of the queue.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (bus.envia_dados === 1'b1 || bus.iniciar === 1'b1)) begin
            if (fila.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: envia=%0b iniciar=%0b tela=%0d expected=none (t=%0t)",
                         bus.envia_dados, bus.iniciar, bus.tela_renderizada, $time);
            end else begin
                e = fila.pop_front();
                if (e.inicio) begin
                    chk("start_iniciar", 32'(bus.iniciar), 32'd1);
                    chk("start_jogo",    32'(bus.jogo_base_em_andamento), 32'd1);
                    chk("start_cursor",  32'(bus.cursor), 32'(e.cursor));
                end else begin
                    chk("send_envia",   32'(bus.envia_dados), 32'd1);
                    chk("send_tela",    32'(bus.tela_renderizada), 32'(e.tela));
                    chk("send_cursor",  32'(bus.cursor), 32'(e.cursor));
                    chk("send_timeout", 32'(bus.timeout_menu), 32'(e.tmo));
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        logic [1:0] cur_exp [4];
        cur_exp[0] = 2'd1; cur_exp[1] = 2'd2; cur_exp[2] = 2'd3; cur_exp[3] = 2'd0;
        bus.ocorreu_jogada = 1'b0; bus.tiro = 1'b0; bus.especial = 1'b0; bus.pronto = 1'b0;

        // Reset values, then the first menu frame.
        repeat (2) @(negedge clock);
        chk_reset_vals("reset0");
        push_send(8'd1, 2'd0, 1'b0);
        @(posedge clock); #1 reset = 1'b0;
        wait_state(E_MENU, 20, "boot_menu");
        chk("boot_tela", 32'(bus.tela_renderizada), 32'd1);
        chk("boot_cursor", 32'(bus.cursor), 32'd0);

        // Cursor wraps over four entries, each move redraws the menu.
        for (int i = 0; i < 4; i++) begin
            push_send(8'd1, cur_exp[i], 1'b0);
            press(1'b0, 1'b1);
            wait_state(E_MENU, 20, "esp_menu");
        end
        chk("wrap_cursor", 32'(bus.cursor), 32'd0);

        // Game: start, end screen, score screen, back to menu.
        push_start();
        press(1'b1, 1'b0);
        wait_state(E_ESPERA_JOGO, 10, "jogo_espera");
        chk("jogo_andamento", 32'(bus.jogo_base_em_andamento), 32'd1);
        chk("jogo_tela_hold", 32'(bus.tela_renderizada), 32'd1);
        push_send(8'd2, 2'd0, 1'b0);
        @(posedge clock); #1 bus.pronto = 1'b1;
        @(posedge clock); #1 bus.pronto = 1'b0;
        wait_state(E_TELA_FINAL, 20, "tela_final");
        push_send(8'd3, 2'd0, 1'b0);
        press(1'b1, 1'b0);
        wait_state(E_REG_PONT, 20, "reg_pont");
        push_send(8'd1, 2'd0, 1'b0);
        press(1'b1, 1'b0);
        wait_state(E_MENU, 20, "pont_menu");
        chk("pont_cursor", 32'(bus.cursor), 32'd0);

        // Info page for entry 2 is code 5; tiro there is ignored; especial returns.
        push_send(8'd1, 2'd1, 1'b0);
        press(1'b0, 1'b1);
        wait_state(E_MENU, 20, "menu_c1");
        push_send(8'd1, 2'd2, 1'b0);
        press(1'b0, 1'b1);
        wait_state(E_MENU, 20, "menu_c2");
        push_send(8'd5, 2'd2, 1'b0);
        press(1'b1, 1'b0);
        wait_state(E_OPCAO, 20, "opcao");
        press(1'b1, 1'b0);
        wait_state(E_OPCAO, 5, "opcao_tiro_stay");
        chk("opcao_tela", 32'(bus.tela_renderizada), 32'd5);
        push_send(8'd1, 2'd2, 1'b0);
        press(1'b0, 1'b1);
        wait_state(E_MENU, 20, "opcao_menu");

        // Menu with cursor!=0 is armed: the timeout redraws the menu with cursor 0.
        push_send(8'd1, 2'd0, 1'b1);
        wait_state(E_ENVIA, 30, "menu_timeout_envia");
        wait_state(E_MENU, 20, "menu_timeout_back");
        chk("menu_timeout_cursor", 32'(bus.cursor), 32'd0);

        // TELA_FINAL with no input: exactly 10 idle cycles, then a timeout send.
        push_start();
        press(1'b1, 1'b0);
        wait_state(E_ESPERA_JOGO, 10, "jogo2");
        push_send(8'd2, 2'd0, 1'b0);
        @(posedge clock); #1 bus.pronto = 1'b1;
        @(posedge clock); #1 bus.pronto = 1'b0;
        wait_state(E_TELA_FINAL, 20, "tela_final2");
        push_send(8'd1, 2'd0, 1'b1);
        n = 0;
        while (bus.db_estado === E_TELA_FINAL && n < 50) begin
            n++;
            @(negedge clock);
        end
        chk("idle_cycles_before_timeout", 32'(n), 32'd10);
        wait_state(E_MENU, 20, "timeout_menu_back");

        // A jogada in the would-be timeout cycle wins; no timeout send follows.
        push_start();
        press(1'b1, 1'b0);
        wait_state(E_ESPERA_JOGO, 10, "jogo3");
        push_send(8'd2, 2'd0, 1'b0);
        @(posedge clock); #1 bus.pronto = 1'b1;
        @(posedge clock); #1 bus.pronto = 1'b0;
        wait_state(E_TELA_FINAL, 20, "tela_final3");
        repeat (9) @(negedge clock);
        bus.ocorreu_jogada = 1'b1;
        @(posedge clock); #1 bus.ocorreu_jogada = 1'b0;
        @(negedge clock);
        chk("jogada_wins_estado", 32'(bus.db_estado), 32'(E_REGISTRA));
        chk("jogada_wins_timeout", 32'(bus.timeout_menu), 32'd0);
        wait_state(E_TELA_FINAL, 10, "jogada_none_back");

        // Reset while waiting for the sender (screen code 3 pending).
        auto_fim = 1'b0;
        push_send(8'd3, 2'd0, 1'b0);
        press(1'b1, 1'b0);
        wait_state(E_ESPERA_ENVIA, 10, "espera_envia");
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        #1 chk_reset_vals("reset_envia");
        auto_fim = 1'b1;
        push_send(8'd1, 2'd0, 1'b0);
        @(posedge clock); #1 reset = 1'b0;
        wait_state(E_MENU, 20, "reset_envia_menu");

        // Reset during the game.
        push_start();
        press(1'b1, 1'b0);
        wait_state(E_ESPERA_JOGO, 10, "jogo4");
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;
        #1 chk_reset_vals("reset_jogo");
        push_send(8'd1, 2'd0, 1'b0);
        @(posedge clock); #1 reset = 1'b0;
        wait_state(E_MENU, 20, "reset_jogo_menu");

        repeat (5) @(negedge clock);
        chk("queue_drained", 32'(fila.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
